// File: rtl/serial_frame_pkg.sv
// Shared framing constants and FSM state encoding for the serial transmit/receive pair.
// No logic and no latency; both ends import these so the line levels stay in agreement.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic START_LEVEL = 1'b1;
   localparam logic STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/serial_frame_shreg.sv
// Loadable WIDTH-bit shift register with a serial-out tap; shifts toward the tap by one bit per shift_i.
// The load takes effect at the next edge; load wins over shift; there is no backpressure.
module serial_frame_shreg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_dat_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic             ser_o
);

   logic [WIDTH-1:0] sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = load_dat_i;
      end else if (shift_i) begin
         sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], ser_i} : {ser_i, sh_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign ser_o = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Frames a WIDTH-bit word as start/data/(parity)/stop, one bit per clock; the start bit shows one cycle after accept.
// tx_ready is high only in IDLE and STOP; SERIAL_FRAME_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             ser_out,
   output logic             frame_act,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ser_out_q, ser_out_d;
   logic            frame_act_q, frame_act_d;
   logic            done_q, done_d;
   logic            tx_ready_q, tx_ready_d;
   logic            accept;
   logic            shift;
   logic            tap;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   assign accept = tx_valid && tx_ready_q;
   // Every cycle that will display a data bit consumes the tap and advances the register.
   assign shift  = (state_d == ST_DATA);

   serial_frame_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept),
      .load_dat_i (tx_data),
      .shift_i    (shift),
      .ser_i      (1'b0),
      .ser_o      (tap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ser_out_q   <= 1'b0;
         frame_act_q <= 1'b0;
         done_q      <= 1'b0;
         tx_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         frame_act_q <= frame_act_d;
         done_q      <= done_d;
         tx_ready_q  <= tx_ready_d;
      end
   end

`ifdef SERIAL_FRAME_TX_PARITY_EN
   assign parity_d = accept ? ^tx_data : parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == ST_DATA) ? cnt_q + 1'b1 : '0;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_START;
         ST_START: state_d = ST_DATA;
         ST_DATA: begin
            if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef SERIAL_FRAME_TX_PARITY_EN
         ST_PARITY: state_d = ST_STOP;
`endif
         ST_STOP:  state_d = accept ? ST_START : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q.
   always_comb begin
      ser_out_d   = 1'b0;
      frame_act_d = 1'b1;
      done_d      = 1'b0;
      tx_ready_d  = 1'b0;
      case (state_d)
         ST_START: ser_out_d = START_LEVEL;
         ST_DATA:  ser_out_d = tap;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         ST_PARITY: ser_out_d = parity_q;
`endif
         ST_STOP: begin
            ser_out_d  = STOP_LEVEL;
            done_d     = 1'b1;
            tx_ready_d = 1'b1;
         end
         default: begin
            frame_act_d = 1'b0;
            tx_ready_d  = 1'b1;
         end
      endcase
   end

   assign tx_ready  = tx_ready_q;
   assign ser_out   = ser_out_q;
   assign frame_act = frame_act_q;
   assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an MSB-first and an LSB-first instance share one stimulus stream.
// A frame-list model is checked every cycle, and directed frames are compared against literal bit patterns.
module tb_serial_frame_tx;

   localparam int W = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam int FL = W + 3;
   localparam logic [31:0] E_A5  = 32'b1_10100101_0_0;
   localparam logic [31:0] E_3C  = 32'b1_00111100_0_0;
   localparam logic [31:0] E_01M = 32'b1_00000001_1_0;
   localparam logic [31:0] E_01L = 32'b1_10000000_1_0;
   localparam logic [31:0] E_07M = 32'b1_00000111_1_0;
   localparam logic [31:0] E_07L = 32'b1_11100000_1_0;
   localparam logic [31:0] E_ACT = 32'h7FF;
`else
   localparam int FL = W + 2;
   localparam logic [31:0] E_A5  = 32'b1_10100101_0;
   localparam logic [31:0] E_3C  = 32'b1_00111100_0;
   localparam logic [31:0] E_01M = 32'b1_00000001_0;
   localparam logic [31:0] E_01L = 32'b1_10000000_0;
   localparam logic [31:0] E_07M = 32'b1_00000111_0;
   localparam logic [31:0] E_07L = 32'b1_11100000_0;
   localparam logic [31:0] E_ACT = 32'h3FF;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tx_valid = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         rdy_m, ser_m, act_m, done_m;
   logic         rdy_l, ser_l, act_l, done_l;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(rdy_m), .ser_out(ser_m), .frame_act(act_m), .done(done_m)
   );

   serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(rdy_l), .ser_out(ser_l), .frame_act(act_l), .done(done_l)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each accepted word becomes a list of per-cycle line values, replayed one per clock.
   typedef struct packed {
      logic sm;
      logic sl;
      logic act;
      logic dn;
   } ent_t;

   ent_t cur = '0;
   ent_t pend[$];
   bit   model_on = 1'b0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         pend.delete();
         cur = '0;
         model_on = 1'b1;
      end else begin
         if (tx_valid && pend.size() == 0) begin
            pend.push_back(ent_t'(4'b1110));
            for (int i = 0; i < W; i++)
               pend.push_back(ent_t'({tx_data[W-1-i], tx_data[i], 2'b10}));
`ifdef SERIAL_FRAME_TX_PARITY_EN
            pend.push_back(ent_t'({^tx_data, ^tx_data, 2'b10}));
`endif
            pend.push_back(ent_t'(4'b0011));
         end
         if (pend.size() != 0) cur = pend.pop_front();
         else cur = '0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_on) begin
         chk("ser_msb",   ser_m,  cur.sm);
         chk("ser_lsb",   ser_l,  cur.sl);
         chk("act_msb",   act_m,  cur.act);
         chk("act_lsb",   act_l,  cur.act);
         chk("done_msb",  done_m, cur.dn);
         chk("done_lsb",  done_l, cur.dn);
         chk("ready_msb", rdy_m,  pend.size() == 0);
         chk("ready_lsb", rdy_l,  pend.size() == 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_word(input logic [W-1:0] w);
      int n = 0;
      tx_data  = w;
      tx_valid = 1'b1;
      while (!rdy_m && n < 50) begin
         step();
         n++;
      end
      chk("ready_wait", rdy_m, 1'b1);
      step();
   endtask

   // Captures n cycles of line/act/done; optionally drops tx_valid right after the last-captured stop edge.
   task automatic capture(input int n, input bit release_last,
                          output logic [31:0] cm, output logic [31:0] cl,
                          output logic [31:0] cd, output logic [31:0] ca);
      cm = '0; cl = '0; cd = '0; ca = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cm = {cm[30:0], ser_m};
         cl = {cl[30:0], ser_l};
         cd = {cd[30:0], done_m};
         ca = {ca[30:0], act_m};
         if (release_last && i == n - 1) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
         end
      end
   endtask

   initial begin
      logic [31:0] cm, cl, cd, ca;

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      chk("idle_ready", rdy_m, 1'b1);
      chk("idle_line", ser_m, 1'b0);

      // Single frame; tx_data changes right after accept and must not matter.
      accept_word(8'hA5);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      capture(FL, 1'b0, cm, cl, cd, ca);
      chk("a5_msb_bits", cm, E_A5);
      chk("a5_lsb_bits", cl, E_A5);
      chk("a5_done", cd, 32'd1);
      chk("a5_act", ca, E_ACT);
      repeat (3) step();

      accept_word(8'h01);
      tx_valid = 1'b0;
      capture(FL, 1'b0, cm, cl, cd, ca);
      chk("x01_msb_bits", cm, E_01M);
      chk("x01_lsb_bits", cl, E_01L);
      repeat (2) step();

      // Back-to-back: second word presented during the first frame, taken in its stop cycle.
      accept_word(8'hA5);
      tx_data = 8'h3C;
      capture(FL, 1'b1, cm, cl, cd, ca);
      chk("b2b_first_bits", cm, E_A5);
      chk("b2b_first_done", cd, 32'd1);
      capture(FL, 1'b0, cm, cl, cd, ca);
      chk("b2b_second_bits", cm, E_3C);
      chk("b2b_second_lsb", cl, E_3C);
      chk("b2b_second_act", ca, E_ACT);
      repeat (2) step();

      // Reset during data bit 4 of 0xFF.
      accept_word(8'hFF);
      tx_valid = 1'b0;
      repeat (5) step();
      chk("ff_bit4", ser_m, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_line", ser_m, 1'b0);
      chk("rst_mid_act", act_m, 1'b0);
      chk("rst_mid_ready", rdy_m, 1'b1);

      accept_word(8'h07);
      tx_valid = 1'b0;
      capture(FL, 1'b0, cm, cl, cd, ca);
      chk("x07_msb_bits", cm, E_07M);
      chk("x07_lsb_bits", cl, E_07L);
      chk("x07_done", cd, 32'd1);
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete by %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial transmitter that drives the single-bit serial line consumed by the team's serial shift-register receive path.
- Accepts a WIDTH-bit word through a valid/ready handshake and frames it as: start bit, WIDTH data bits, stop bit.
- The frame is shifted out one bit per clock.
- Sits between the parallel datapath and the serial link, as the transmit end of the serial-in/serial-out chain.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- MSB_FIRST, 1, 1 = data shifted MSB first; 0 = LSB first.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  WIDTH  word to transmit; sampled only on an accept cycle.
- tx_valid  input  1  upstream has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  registered serial line; 0 when idle.
- frame_act  output  1  high for every cycle ser_out carries a frame bit.
- done  output  1  one-cycle pulse in the stop-bit cycle.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at an edge): state=IDLE, ser_out=0, frame_act=0, done=0, bit counter=0, shift register=0.
  - Reset overrides any frame in progress.
  - ser_out returns to 0 on the same edge.
  - The partially sent word is discarded.
- Accept: valid&&ready at a rising edge.
  - The word is latched into the shift register.
  - tx_data is ignored at all other times.
- FSM states IDLE, START, DATA, STOP. All outputs are registered (Moore).
- IDLE: tx_ready=1, ser_out=0, frame_act=0.
  - On accept: go to START.
- START: ser_out=1, frame_act=1, tx_ready=0.
  - Next state DATA; counter=0.
- DATA: ser_out = current bit of the shift register, MSB or LSB per MSB_FIRST.
  - Shift register moves one position per cycle; counter increments.
  - After WIDTH cycles (counter==WIDTH-1), go to STOP.
- STOP: ser_out=0, frame_act=1, done=1, tx_ready=1.
  - On accept: go to START (back-to-back, no idle gap).
  - Otherwise: go to IDLE.
- Latency: accept at edge N.
  - Start bit visible after edge N (cycle N+1).
  - Data bit 0 in cycle N+2; last data bit in cycle N+1+WIDTH.
  - Stop bit in cycle N+2+WIDTH.
  - Frame length is WIDTH+2 cycles.
- tx_valid held high with no accept (START/DATA): no effect; the upstream word must be held until accepted.
- tx_valid deasserted in STOP: clean return to IDLE; ser_out stays 0.
- Counter width is $clog2(WIDTH+1). The counter never wraps inside a frame and is cleared on START.

Optional Feature:
- Macro SERIAL_FRAME_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - ser_out = even parity (XOR of all WIDTH data bits, latched at accept); frame_act=1.
  - Frame length becomes WIDTH+3; the stop bit moves one cycle later.
- Undefined: no PARITY state and no parity logic; frame length WIDTH+2.

Decomposition:
- Shared package serial_frame_pkg holds:
  - State encoding typedef/localparams: ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - START_LEVEL=1 and STOP_LEVEL=0, so the receiver uses identical framing constants.
- One natural sub-module: serial_frame_shreg.
  - Loadable WIDTH-bit shift register with direction parameter and serial-out tap.
  - Reused by the receiver as its SIPO.
- FSM and counter stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0, tx_valid=0 for 10 cycles -> ser_out=0, frame_act=0, tx_ready=1, done=0 throughout.
- Single frame: WIDTH=8, MSB_FIRST=1, tx_data=0xA5 accepted at edge N -> ser_out over cycles N+1..N+10 = 1,1,0,1,0,0,1,0,1,0.
  - frame_act=1 for those 10 cycles; done=1 only at N+10.
- LSB first: MSB_FIRST=0, tx_data=0x01 -> ser_out = 1 (start), 1, then 0×7, then 0 (stop).
- Back-to-back: tx_valid held high with 0xA5 then 0x3C (second word accepted in STOP cycle) -> second start bit at cycle N+11, no gap.
  - Second data bits 0,0,1,1,1,1,0,0.
- Reset mid-frame, hold and parity:
  - rst=1 during data bit 4 of 0xFF -> next cycle ser_out=0, state IDLE, tx_ready=1; a new word sends a complete frame.
  - tx_data changed during DATA -> transmitted bits unchanged.
  - With SERIAL_FRAME_TX_PARITY_EN: 0xA5 -> parity bit 0 at cycle N+10, stop at N+11; 0x07 -> parity bit 1.
